muldiv_unit: RTL
================

MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-003 SHALL have port start  input  1  request from EX stage, qualified by RV32M opcode.
REQ-004 SHALL have port funct3_E  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port SrcAE  input  32  rs1 operand after forwarding.
REQ-006 SHALL have port SrcBE  input  32  rs2 operand after forwarding.
REQ-007 SHALL have port flush  input  1  abort in-flight operation.
REQ-008 SHALL have port busy  output  1  iterative divide in progress.
REQ-009 SHALL have port StallM  output  1  combinational stall request to the hazard unit.
REQ-010 SHALL have port done  output  1  one-cycle pulse; result valid.
REQ-011 SHALL have port MulDivResultE  output  32  registered result.

Function
REQ-012 SHALL implement a 3-state FSM: IDLE, DIV, DONE.
REQ-013 SHALL accept start only in IDLE or DONE; start in DIV SHALL be ignored.
REQ-014 On acceptance, operands and funct3 SHALL be latched; later input changes SHALL not affect the result.
REQ-015 MUL-family ops SHALL go IDLE->DONE, done=1 on the cycle after acceptance (latency 1).
REQ-016 MUL SHALL return product[31:0]; MULH product[63:32] signed x signed; MULHSU signed rs1 x unsigned rs2; MULHU unsigned x unsigned.
REQ-017 Divide ops SHALL use radix-2 restoring division on 32-bit magnitudes, one quotient bit per cycle, with a 5-bit iteration counter.
REQ-018 Normal divide SHALL run in DIV for exactly 32 cycles (acceptance T -> DIV T+1..T+32), then done=1 at T+33.
REQ-019 Signed quotient SHALL be negated when operand signs differ; signed remainder SHALL take the dividend's sign.
REQ-020 Divide by zero SHALL take a fast path (done at T+1): quotient 0xFFFFFFFF (DIV and DIVU); remainder = dividend.
REQ-021 Signed overflow (0x80000000 / 0xFFFFFFFF, DIV/REM) SHALL take a fast path (done at T+1): quotient 0x80000000, remainder 0.
REQ-022 busy SHALL equal (state==DIV).
REQ-023 StallM SHALL equal busy OR (start AND funct3_E[2] AND state!=DIV AND not fast-path).
REQ-024 StallM SHALL be low in the done cycle.
REQ-025 done SHALL equal (state==DONE).
REQ-026 MulDivResultE SHALL update only on entry to DONE and hold until the next completion.
REQ-027 DONE with no start SHALL return to IDLE next cycle.
REQ-028 DONE with start SHALL accept the new op (back-to-back) with the same latencies.
REQ-029 flush SHALL force state IDLE next cycle, with no done pulse; MulDivResultE unchanged.
REQ-030 flush SHALL take priority over start in the same cycle.
REQ-031 Any op with rd=x0 SHALL be executed normally; write suppression is the writeback stage's job.

Reset
REQ-032 rst=1 on a clock edge SHALL set state IDLE, counter 0, busy 0, done 0, MulDivResultE 0, and all internal operand/quotient/remainder registers 0.
REQ-033 rst SHALL override flush and start.
REQ-034 rst asserted mid-divide SHALL abort with no done pulse.
REQ-035 StallM SHALL be 0 while rst=1 unless start is driven.

Verification
REQ-036 MUL 7 x -3 (0x00000007, 0xFFFFFFFD) -> done at T+1, result 0xFFFFFFEB; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
REQ-037 DIV -20 / 3 -> busy T+1..T+32, StallM high T..T+32, done at T+33 with 0xFFFFFFFA; REM same operands -> 0xFFFFFFFE.
REQ-038 DIVU 100/0 -> done T+1, 0xFFFFFFFF; REMU 100/0 -> 0x00000064; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0.
REQ-039 DIVU 0xFFFFFFFF / 0x10 starts; start pulses at T+5 are ignored; flush at T+10 -> IDLE at T+11, no done, result unchanged.
REQ-040 Back-to-back: DIVU 9/2 done at T+33 with start MULHSU 0xFFFFFFFF x 2 in the same cycle -> result 4, then result 0xFFFFFFFF at T+34.
REQ-041 rst at T+15 of a divide -> all outputs 0 next cycle; a new MUL accepted after reset completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// ---------------------------------------------------------------------------
// MuldivUnit (module muldiv_unit)
// RV32M multiply/divide execution unit sitting beside the EX stage.
// Multiplies complete in one cycle; divides iterate one quotient bit per cycle
// using radix-2 restoring division, with fast paths for divide-by-zero and
// signed overflow.
//
// Ports
//   clk            : single clock, all state changes on the rising edge
//   rst            : synchronous active-high reset
//   start          : request from EX (already qualified by the RV32M opcode)
//   funct3_E       : operation select (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU)
//   SrcAE, SrcBE   : rs1 / rs2 operands after forwarding
//   flush          : abort any in-flight operation
//   busy           : iterative divide in progress
//   StallM         : combinational stall request to the hazard unit
//   done           : one-cycle pulse, MulDivResultE is valid
//   MulDivResultE  : registered result, held until the next completion
// ---------------------------------------------------------------------------
module muldiv_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  funct3_E,
   input  logic [31:0] SrcAE,
   input  logic [31:0] SrcBE,
   input  logic        flush,
   output logic        busy,
   output logic        StallM,
   output logic        done,
   output logic [31:0] MulDivResultE
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [31:0] rem_q, rem_d;
   logic [31:0] quot_q, quot_d;
   logic [31:0] divisor_q, divisor_d;
   logic        negQuot_q, negQuot_d;
   logic        negRem_q, negRem_d;
   logic        isRem_q, isRem_d;
   logic [31:0] result_q, result_d;

   // Decode of the incoming request. Everything the result depends on is
   // either folded into result_q at acceptance (multiply, fast paths) or
   // captured into the divide registers, so later input changes are harmless.
   logic        isDivOp, isSignedDiv, isRemOp;
   logic        divByZero, divOverflow, fastPath;
   logic        accept;
   logic        negA, negB;
   logic [31:0] magA, magB;
   logic [31:0] fastResult;

   always_comb begin
      isDivOp     = funct3_E[2];
      isSignedDiv = ~funct3_E[0];
      isRemOp     = funct3_E[1];
      divByZero   = (SrcBE == 32'd0);
      divOverflow = isSignedDiv && (SrcAE == 32'h8000_0000) && (SrcBE == 32'hFFFF_FFFF);
      fastPath    = isDivOp && (divByZero || divOverflow);
      accept      = start && (state_q != DIV) && !flush;
      negA        = isSignedDiv && SrcAE[31];
      negB        = isSignedDiv && SrcBE[31];
      magA        = negA ? (~SrcAE + 32'd1) : SrcAE;
      magB        = negB ? (~SrcBE + 32'd1) : SrcBE;
      // Divide by zero returns all-ones quotient and the raw dividend as
      // remainder; signed overflow returns the dividend and zero remainder.
      if (divByZero)
         fastResult = isRemOp ? SrcAE : 32'hFFFF_FFFF;
      else
         fastResult = isRemOp ? 32'd0 : 32'h8000_0000;
   end

   // Multiplier: operands are extended to 33 bits so one signed multiply
   // covers signed, unsigned and mixed-sign variants.
   logic               mulSignA, mulSignB;
   logic signed [32:0] mulA, mulB;
   logic signed [65:0] product;
   logic [31:0]        mulResult;

   always_comb begin
      mulSignA  = (funct3_E[1:0] == 2'b01) || (funct3_E[1:0] == 2'b10);
      mulSignB  = (funct3_E[1:0] == 2'b01);
      mulA      = {mulSignA & SrcAE[31], SrcAE};
      mulB      = {mulSignB & SrcBE[31], SrcBE};
      product   = mulA * mulB;
      mulResult = (funct3_E[1:0] == 2'b00) ? product[31:0] : product[63:32];
   end

   // One restoring-division step: shift the next dividend bit into the
   // partial remainder and keep the subtraction only if it did not go
   // negative. quot_q starts as the dividend and fills with quotient bits.
   logic [32:0] remShift;
   logic [33:0] trial;
   logic        qBit;
   logic [31:0] remNext, quotNext, divResult;

   always_comb begin
      remShift  = {rem_q, quot_q[31]};
      trial     = {1'b0, remShift} - {2'b00, divisor_q};
      qBit      = ~trial[33];
      remNext   = qBit ? trial[31:0] : remShift[31:0];
      quotNext  = {quot_q[30:0], qBit};
      if (isRem_q)
         divResult = negRem_q ? (~remNext + 32'd1) : remNext;
      else
         divResult = negQuot_q ? (~quotNext + 32'd1) : quotNext;
   end

   // Next-state logic. DONE behaves like IDLE for acceptance so a new
   // operation can start in the same cycle a result is delivered.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      rem_d     = rem_q;
      quot_d    = quot_q;
      divisor_d = divisor_q;
      negQuot_d = negQuot_q;
      negRem_d  = negRem_q;
      isRem_d   = isRem_q;
      result_d  = result_q;

      case (state_q)
         IDLE, DONE: begin
            if (accept) begin
               if (isDivOp && !fastPath) begin
                  state_d   = DIV;
                  cnt_d     = 5'd0;
                  rem_d     = 32'd0;
                  quot_d    = magA;
                  divisor_d = magB;
                  negQuot_d = negA ^ negB;
                  negRem_d  = negA;
                  isRem_d   = isRemOp;
               end else begin
                  state_d  = DONE;
                  result_d = isDivOp ? fastResult : mulResult;
               end
            end else begin
               state_d = IDLE;
            end
         end
         DIV: begin
            rem_d  = remNext;
            quot_d = quotNext;
            cnt_d  = cnt_q + 5'd1;
            if (cnt_q == 5'd31) begin
               state_d  = DONE;
               result_d = divResult;
            end
         end
         default: state_d = IDLE;
      endcase

      // A flush wins over everything except reset and leaves the last
      // delivered result untouched.
      if (flush) begin
         state_d  = IDLE;
         result_d = result_q;
      end
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= 5'd0;
         rem_q     <= 32'd0;
         quot_q    <= 32'd0;
         divisor_q <= 32'd0;
         negQuot_q <= 1'b0;
         negRem_q  <= 1'b0;
         isRem_q   <= 1'b0;
         result_q  <= 32'd0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         rem_q     <= rem_d;
         quot_q    <= quot_d;
         divisor_q <= divisor_d;
         negQuot_q <= negQuot_d;
         negRem_q  <= negRem_d;
         isRem_q   <= isRem_d;
         result_q  <= result_d;
      end
   end

   // The stall is raised in the acceptance cycle of a long divide so the
   // pipeline freezes before the first iteration. The busy term is masked
   // while rst is high because the state register has not cleared yet.
   always_comb begin
      busy          = (state_q == DIV);
      done          = (state_q == DONE);
      MulDivResultE = result_q;
      StallM        = (busy && !rst) || (start && isDivOp && !busy && !fastPath);
   end

endmodule
